// File: rtl/fpu_add_arbiter_if.sv
// Requester and adder signal bundle for the shared adder arbiter.
// master = arbiter side, slave = requesters plus adder side.
interface fpu_add_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_op_a;
    logic [32*N_REQ-1:0] req_op_b;
    logic [N_REQ-1:0]    req_sub;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_data;
    logic [3:0]          rsp_status;
    logic [31:0]         fpu_op_a;
    logic [31:0]         fpu_op_b;
    logic [2:0]          fpu_stage;
    logic [31:0]         fpu_data;
    logic [3:0]          fpu_status;

    modport master (
        input  req_valid, req_op_a, req_op_b, req_sub,
        input  fpu_stage, fpu_data, fpu_status,
        output req_ready, rsp_valid, rsp_data, rsp_status,
        output fpu_op_a, fpu_op_b
    );

    modport slave (
        output req_valid, req_op_a, req_op_b, req_sub,
        output fpu_stage, fpu_data, fpu_status,
        input  req_ready, rsp_valid, rsp_data, rsp_status,
        input  fpu_op_a, fpu_op_b
    );
endinterface

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one free-running adder between requesters.
// Each job flushes one adder pass, captures the next, then responds.
module fpu_add_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clock_100kHz,
    input  logic                reset,
    fpu_add_arbiter_if.master   bus,
    output logic                busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   id;
    logic [PW-1:0]   grant;
    logic            grant_any;
    logic [2:0]      stage_q;
    logic            fpu_done;
    logic [CW-1:0]   cnt;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [31:0]     data_q;
    logic [3:0]      status_q;
    logic            load;
    logic            capture;
    logic            expire;

    assign fpu_done = (bus.fpu_stage == 3'd4) && (stage_q != 3'd4);

    assign bus.fpu_op_a   = op_a;
    assign bus.fpu_op_b   = op_b;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_status = status_q;
    assign busy           = (state != IDLE);

    // Pick the first pending requester at or above ptr, wrapping around.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[PW'((int'(ptr) + k) % N_REQ)]) begin
                grant     = PW'((int'(ptr) + k) % N_REQ);
                grant_any = 1'b1;
            end
        end
    end

    // Accept pulse only while idle; response pulse to the job owner.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state == IDLE && reset && grant_any) begin
            bus.req_ready = N_REQ'(1) << grant;
        end
        if (state == RESP) begin
            bus.rsp_valid = N_REQ'(1) << id;
        end
    end

    // State register.
    always_ff @(posedge clock_100kHz) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; the limit aborts a job unless the capture pass completes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == CNT_MAX) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end else if (fpu_done) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (fpu_done) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else if (cnt == CNT_MAX) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, pointer, timeout counter and result registers.
    always_ff @(posedge clock_100kHz) begin
        if (!reset) begin
            ptr      <= '0;
            id       <= '0;
            stage_q  <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            stage_q <= bus.fpu_stage;
            if (load) begin
                op_a <= bus.req_op_a[{grant, 5'd0} +: 32];
                op_b <= bus.req_op_b[{grant, 5'd0} +: 32]
                        ^ {bus.req_sub[grant], 31'd0};
                id   <= grant;
                ptr  <= (grant == LAST) ? '0 : grant + PW'(1);
                cnt  <= '0;
            end else if (state == ISSUE || state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (capture) begin
                data_q   <= bus.fpu_data;
                status_q <= bus.fpu_status;
            end else if (expire) begin
                data_q   <= '0;
                status_q <= 4'd15;
            end
        end
    end
endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Bench for fpu_add_arbiter: free-running adder model, job-level
// reference model checked every cycle, plus directed literal checks.
module tb_fpu_add_arbiter;
    localparam int N   = 4;
    localparam int TMO = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_add_arbiter_if #(.N_REQ(N)) bus();
    logic busy;

    logic [N-1:0]    valid = '0;
    logic [N-1:0]    sub = '0;
    logic [32*N-1:0] opa = '0;
    logic [32*N-1:0] opb = '0;
    logic [2:0]      stage = 3'd0;
    logic [31:0]     fdata = '0;
    logic [3:0]      fstat = '0;
    logic            stuck = 1'b0;
    int              hold4 = 1;
    int              hcnt = 0;
    logic [31:0]     la = '0;
    logic [31:0]     lb = '0;

    assign bus.req_valid  = valid;
    assign bus.req_op_a   = opa;
    assign bus.req_op_b   = opb;
    assign bus.req_sub    = sub;
    assign bus.fpu_stage  = stage;
    assign bus.fpu_data   = fdata;
    assign bus.fpu_status = fstat;

    fpu_add_arbiter #(
        .N_REQ(N),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_100kHz(clk),
        .reset(rst_n),
        .bus(bus),
        .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Adder: latches operands at stage 0, result appears at stage 4.
    always @(posedge clk) begin
        if (stage == 3'd0) begin
            la <= bus.fpu_op_a;
            lb <= bus.fpu_op_b;
        end
        if (stage == 3'd3) begin
            fdata <= la + lb;
            fstat <= la[3:0] ^ lb[3:0];
        end
        if (stage == 3'd4) begin
            if (hcnt <= 1) stage <= 3'd0;
            else hcnt <= hcnt - 1;
        end else if (stage == 3'd3) begin
            if (!stuck) begin
                stage <= 3'd4;
                hcnt  <= hold4;
            end
        end else begin
            stage <= stage + 3'd1;
        end
    end

    // Reference model: one job in flight, counted in adder completions.
    bit          m_busy = 0;
    bit          m_resp = 0;
    int          m_id = 0;
    int          m_ptr = 0;
    int          m_dones = 0;
    int          m_cyc = 0;
    logic [31:0] m_opa = '0;
    logic [31:0] m_opb = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_stat = '0;
    logic [2:0]  m_prev = '0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit done;
        int g;
        done = (stage == 3'd4) && (m_prev != 3'd4);
        if (!rst_n) begin
            m_busy = 0; m_resp = 0; m_id = 0; m_ptr = 0;
            m_opa = '0; m_opb = '0; m_data = '0; m_stat = '0;
            m_prev = '0;
        end else begin
            m_prev = stage;
            if (m_resp) begin
                m_resp = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                g = pick(valid, m_ptr);
                if (g >= 0) begin
                    m_busy  = 1;
                    m_id    = g;
                    m_ptr   = (g + 1) % N;
                    m_opa   = opa[32*g +: 32];
                    m_opb   = opb[32*g +: 32] ^ {sub[g], 31'd0};
                    m_dones = 0;
                    m_cyc   = 0;
                end
            end else begin
                if (done) m_dones++;
                if (done && m_dones == 2) begin
                    m_data = fdata;
                    m_stat = fstat;
                    m_resp = 1;
                end else if (m_cyc == TMO - 1) begin
                    m_data = '0;
                    m_stat = 4'd15;
                    m_resp = 1;
                end
                m_cyc++;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [N-1:0] er;
        logic [N-1:0] ev;
        int g;
        if (chk_en) begin
            er = '0;
            ev = '0;
            g  = pick(valid, m_ptr);
            if (!m_busy && rst_n && g >= 0) er = N'(1) << g;
            if (m_resp) ev = N'(1) << m_id;
            chk("req_ready", bus.req_ready, er);
            chk("rsp_valid", bus.rsp_valid, ev);
            chk("busy", busy, m_busy);
            chk("rsp_data", bus.rsp_data, m_data);
            chk("rsp_status", bus.rsp_status, m_stat);
            chk("fpu_op_a", bus.fpu_op_a, m_opa);
            chk("fpu_op_b", bus.fpu_op_b, m_opb);
        end
    end

    // Log grant and response indices.
    int gq[$];
    int rq[$];
    int rsp_seen = 0;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) gq.push_back(i);
            if (bus.rsp_valid[i]) begin
                rq.push_back(i);
                rsp_seen++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_stage1();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (stage == 3'd1) ok = 1;
        end
        if (!ok) chk("stage1_timeout", 0, 1);
    endtask

    task automatic request(input int r, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        bit ok;
        valid[r] = 1'b1;
        sub[r]   = s;
        opa[32*r +: 32] = a;
        opb[32*r +: 32] = b;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) ok = 1;
        end
        if (!ok) chk("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cycles,
                            output bit ok);
        cycles = 0;
        ok = 0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (bus.rsp_valid != '0) ok = 1;
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  ok;
        int  rs0;

        rst_n = 1'b0;
        cyc(3);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_op_a", bus.fpu_op_a, 32'h0);
        chk("reset_rsp_valid", bus.rsp_valid, 4'b0000);

        // Single request; the flush pass carries 0+0.
        wait_stage1();
        request(0, 32'h4000_0000, 32'h4000_0000, 1'b0);
        wait_rsp(100, lat, ok);
        chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t1_rsp_data", bus.rsp_data, 32'h8000_0000);
        chk("t1_rsp_status", bus.rsp_status, 4'h0);
        chk("t1_model_data", m_data, 32'h8000_0000);
        @(posedge clk);
        #1;

        // Subtract from requester 2.
        wait_stage1();
        request(2, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        @(negedge clk);
        chk("t2_op_b", bus.fpu_op_b, 32'hC000_0000);
        chk("t2_busy", busy, 1'b1);
        wait_rsp(100, lat, ok);
        chk("t2_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("t2_rsp_data", bus.rsp_data, 32'hFF80_0000);
        sub = '0;
        @(posedge clk);
        #1;

        // Contention after reset, adder holding CHECK for 3 cycles.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        hold4 = 3;
        for (int i = 0; i < N; i++) begin
            opa[32*i +: 32] = 32'h1000_0000 * (i + 1) + i;
            opb[32*i +: 32] = 32'h0000_0105 * (i + 2);
        end
        gq.delete();
        rq.delete();
        valid = 4'b1111;
        for (int j = 0; j < 5; j++) wait_rsp(100, lat, ok);
        @(posedge clk);
        #1;
        valid = '0;
        hold4 = 1;
        cyc(2);
        chk("t3_grants", gq.size(), 5);
        chk("t3_rsps", rq.size(), 5);
        if (gq.size() == 5 && rq.size() == 5) begin
            chk("t3_g0", gq[0], 0);
            chk("t3_g1", gq[1], 1);
            chk("t3_g2", gq[2], 2);
            chk("t3_g3", gq[3], 3);
            chk("t3_g4", gq[4], 0);
            for (int j = 0; j < 5; j++) chk("t3_rsp_id", rq[j], gq[j]);
        end

        // Stuck adder times out, then a normal job follows.
        stuck = 1'b1;
        cyc(8);
        request(1, 32'h1234_5678, 32'h0000_0001, 1'b0);
        wait_rsp(TMO + 20, lat, ok);
        chk("t4_latency", lat, TMO + 1);
        chk("t4_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("t4_rsp_data", bus.rsp_data, 32'h0);
        chk("t4_rsp_status", bus.rsp_status, 4'hF);
        @(posedge clk);
        #1;
        stuck = 1'b0;
        request(3, 32'h0000_0011, 32'h0000_0022, 1'b0);
        wait_rsp(100, lat, ok);
        chk("t4_next_rsp", bus.rsp_valid, 4'b1000);
        chk("t4_next_data", bus.rsp_data, 32'h0000_0033);
        chk("t4_next_status", bus.rsp_status, 4'h3);
        @(posedge clk);
        #1;

        // Adder completions while idle do nothing.
        rs0 = rsp_seen;
        cyc(20);
        chk("t5_no_rsp", rsp_seen, rs0);
        chk("t5_busy", busy, 1'b0);

        // Reset while the capture pass is pending.
        request(2, 32'h0000_0100, 32'h0000_0200, 1'b0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_busy && !m_resp && m_dones == 1) ok = 1;
        end
        if (!ok) chk("t6_wait_timeout", 0, 1);
        rs0 = rsp_seen;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 1'b0);
        chk("t6_rsp_data", bus.rsp_data, 32'h0);
        chk("t6_rsp_status", bus.rsp_status, 4'h0);
        chk("t6_op_a", bus.fpu_op_a, 32'h0);
        chk("t6_op_b", bus.fpu_op_b, 32'h0);
        cyc(20);
        chk("t6_no_rsp", rsp_seen, rs0);
        valid = 4'b1111;
        @(negedge clk);
        chk("t6_first_grant", bus.req_ready, 4'b0001);
        @(posedge clk);
        #1;
        valid = '0;
        wait_rsp(100, lat, ok);
        chk("t6_rsp_valid", bus.rsp_valid, 4'b0001);
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
